sram_handshake_master: RTL and testbench

Bridge from a four-phase (return-to-zero) bundled-data request/acknowledge channel on the asynchronous CPU side to the single-port synchronous RAM bus (addr, shared tri-state data, cs, we, oe). It synchronises the incoming request and sequences one RAM read or write per handshake. It returns read data with the acknowledge, and it never drives the shared data bus while the RAM may be driving it.

---
 rtl/sram_handshake_master_if.sv | 23 ++
 rtl/sram_handshake_master.sv | 115 +++++++++++
 tb/tb_sram_handshake_master.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_handshake_master_if.sv
// Async-side request/acknowledge channel of the SRAM handshake master.
// Four-phase handshake: requester raises req_in with wr_in/addr_in/wdata_in stable, responder raises ack_out (rdata_out valid for reads), requester drops req_in, responder drops ack_out.
interface sram_handshake_master_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  req_in;
  logic                  wr_in;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [DATA_WIDTH-1:0] wdata_in;
  logic                  ack_out;
  logic [DATA_WIDTH-1:0] rdata_out;

  modport master (
    output req_in, wr_in, addr_in, wdata_in,
    input  ack_out, rdata_out
  );

  modport slave (
    input  req_in, wr_in, addr_in, wdata_in,
    output ack_out, rdata_out
  );
endinterface

// File: rtl/sram_handshake_master.sv
// Bridges a four-phase bundled-data request channel onto a single-port synchronous RAM bus,
// one RAM read or write per handshake.
module sram_handshake_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_handshake_master_if.slave cpu,
  output logic                  proto_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [4:0]            state_dbg
);

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_WRITE  = 5'b00010,
    S_READ   = 5'b00100,
    S_RD_CAP = 5'b01000,
    S_ACK    = 5'b10000
  } state_t;

  state_t                state;
  logic                  req_meta;
  logic                  req_s;
  logic                  ack_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_meta <= 1'b0;
      req_s    <= 1'b0;
    end else begin
      req_meta <= cpu.req_in;
      req_s    <= req_meta;
    end
  end

  // Every bus control is registered alongside the state so nothing reaches the RAM or
  // the async side through combinational decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
      ack_q     <= 1'b0;
      proto_err <= 1'b0;
      mem_addr  <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_s) begin
            mem_addr <= cpu.addr_in;
            wdata_q  <= cpu.wdata_in;
            mem_cs   <= 1'b1;
            if (cpu.wr_in) begin
              state  <= S_WRITE;
              mem_we <= 1'b1;
            end else begin
              state  <= S_READ;
              mem_oe <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          state  <= S_ACK;
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
          ack_q  <= 1'b1;
          if (!req_s) proto_err <= 1'b1;
        end
        S_READ: begin
          state <= S_RD_CAP;
          if (!req_s) proto_err <= 1'b1;
        end
        S_RD_CAP: begin
          state   <= S_ACK;
          rdata_q <= mem_data;
          mem_cs  <= 1'b0;
          mem_oe  <= 1'b0;
          ack_q   <= 1'b1;
          if (!req_s) proto_err <= 1'b1;
        end
        S_ACK: begin
          if (!req_s) begin
            state <= S_IDLE;
            ack_q <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
          mem_oe <= 1'b0;
          ack_q  <= 1'b0;
        end
      endcase
    end
  end

  // We is only ever set in WRITE, so the master cannot overlap the RAM's read drive.
  assign mem_data      = (mem_cs && mem_we) ? wdata_q : {DATA_WIDTH{1'bz}};
  assign cpu.ack_out   = ack_q;
  assign cpu.rdata_out = rdata_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_sram_handshake_master.sv
// Bench for sram_handshake_master: directed plus random four-phase transactions against
// a behavioural memory model and an expected-read queue.
module tb_sram_handshake_master;

  logic        clk;
  logic        reset;
  logic        proto_err;
  logic [3:0]  mem_addr;
  wire  [31:0] mem_data;
  logic        mem_cs;
  logic        mem_we;
  logic        mem_oe;
  logic [4:0]  state_dbg;

  sram_handshake_master_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) cpu ();

  sram_handshake_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu),
    .proto_err (proto_err),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_oe    (mem_oe),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // synchronous RAM: output register loads on a read edge and drives while cs & oe & !we
  logic [31:0] ram [16];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
    if (mem_cs && mem_oe && !mem_we) ram_q <= ram[mem_addr];
  end
  assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram_q : 32'bz;

  int bus_viol = 0;
  always @(negedge clk) begin
    if ((mem_we && mem_oe) || ((mem_we || mem_oe) && !mem_cs)) bus_viol++;
  end

  // scoreboard / reference model
  logic [31:0] exp_mem [16];
  logic [31:0] exp_q[$];
  logic [31:0] exp_rdata;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // driver: one complete four-phase transaction, called at a negedge
  task automatic do_txn(input bit wr, input logic [3:0] a, input logic [31:0] d);
    int lat, we_cyc, oe_cyc, n;
    bit got_ack;
    logic [31:0] exp_rd;
    cpu.wr_in    = wr;
    cpu.addr_in  = a;
    cpu.wdata_in = d;
    cpu.req_in   = 1'b1;
    if (wr) exp_mem[a] = d;
    else exp_q.push_back(exp_mem[a]);
    lat = 0; we_cyc = 0; oe_cyc = 0; got_ack = 1'b0;
    while (!got_ack && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
      if (mem_cs && mem_we) begin
        we_cyc++;
        check("wr_addr", {28'd0, mem_addr}, {28'd0, a});
        check("wr_data", mem_data, d);
      end
      if (mem_cs && mem_oe) begin
        oe_cyc++;
        check("rd_addr", {28'd0, mem_addr}, {28'd0, a});
        if (oe_cyc == 2) check("rd_bus", mem_data, exp_mem[a]);
      end
      got_ack = cpu.ack_out;
    end
    check("ack_seen", {31'd0, got_ack}, 32'd1);
    check("ack_latency", lat, wr ? 32'd4 : 32'd5);
    if (wr) begin
      check("we_cycles", we_cyc, 32'd1);
      check("rdata_hold", cpu.rdata_out, exp_rdata);
    end else begin
      check("oe_cycles", oe_cyc, 32'd2);
      exp_rd = exp_q.pop_front();
      exp_rdata = exp_rd;
      check("rdata", cpu.rdata_out, exp_rd);
    end
    cpu.req_in = 1'b0;
    n = 0;
    while (cpu.ack_out && n < 10) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check("ack_release", {31'd0, (n >= 2 && n <= 3)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses, waited;
    bit prev_ack;
    logic [3:0] a;
    for (int i = 0; i < 16; i++) exp_mem[i] = 32'd0;
    exp_rdata    = 32'd0;
    reset        = 1'b0;
    cpu.req_in   = 1'b0;
    cpu.wr_in    = 1'b0;
    cpu.addr_in  = 4'd0;
    cpu.wdata_in = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, cpu.ack_out}, 32'd0);
    check("rst_rdata", cpu.rdata_out, 32'd0);
    check("rst_proto_err", {31'd0, proto_err}, 32'd0);
    check("rst_ctrl", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
    check("rst_addr", {28'd0, mem_addr}, 32'd0);
    check("rst_state_onehot", $countones(state_dbg), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // directed: basic write/read, then address extremes
    do_txn(1'b1, 4'd3, 32'hDEADBEEF);
    do_txn(1'b0, 4'd3, 32'd0);
    do_txn(1'b1, 4'd0, 32'h00000001);
    do_txn(1'b1, 4'd15, 32'hFFFFFFFF);
    do_txn(1'b0, 4'd0, 32'd0);
    do_txn(1'b0, 4'd15, 32'd0);

    // fill every address, then random mix with random idle gaps
    for (int i = 1; i < 15; i++) if (i != 3) do_txn(1'b1, i[3:0], $urandom);
    for (int i = 0; i < 24; i++) begin
      a = 4'($urandom_range(0, 15));
      do_txn(1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // reset during RD_CAP
    do_txn(1'b1, 4'd5, 32'h12345678);
    do_txn(1'b0, 4'd5, 32'd0);
    cpu.wr_in = 1'b0; cpu.addr_in = 4'd3; cpu.req_in = 1'b1;
    waited = 0; pulses = 0;
    while (pulses < 2 && waited < 20) begin
      @(negedge clk); waited++;
      if (mem_cs && mem_oe) pulses++;
    end
    check("rdcap_reached", pulses, 32'd2);
    #1 reset = 1'b0;
    #1;
    check("midrd_ctrl", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
    check("midrd_ack", {31'd0, cpu.ack_out}, 32'd0);
    check("midrd_rdata", cpu.rdata_out, 32'd0);
    check("midrd_addr", {28'd0, mem_addr}, 32'd0);
    exp_rdata = 32'd0;
    cpu.req_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu.ack_out) pulses++;
    end
    check("no_ack_after_reset", pulses, 32'd0);

    // protocol violation: req_in dropped right after the read starts
    cpu.wr_in = 1'b0; cpu.addr_in = 4'd3; cpu.req_in = 1'b1;
    @(negedge clk); @(negedge clk);
    cpu.req_in = 1'b0;
    pulses = 0; prev_ack = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (cpu.ack_out && !prev_ack) pulses++;
      prev_ack = cpu.ack_out;
    end
    check("perr_set", {31'd0, proto_err}, 32'd1);
    check("perr_ack_pulses", {31'd0, pulses <= 1}, 32'd1);
    check("perr_ack_low", {31'd0, cpu.ack_out}, 32'd0);
    check("perr_rdata", cpu.rdata_out, exp_mem[3]);
    exp_rdata = exp_mem[3];
    do_txn(1'b1, 4'd9, 32'hA5A55A5A);
    do_txn(1'b0, 4'd9, 32'd0);
    check("perr_sticky", {31'd0, proto_err}, 32'd1);

    check("bus_exclusive", bus_viol, 32'd0);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
